// File: rtl/fetch_unit_if.sv
// fetch_if: memory read port, instruction output port and core control signals of the fetch unit
interface fetch_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  modport master (
    output mem_addr, mem_rstrb, instr, instr_pc, instr_valid, halted,
    input  mem_rdata, instr_ready, redirect, redirect_pc, halt
  );
  modport slave (
    input  mem_addr, mem_rstrb, instr, instr_pc, instr_valid, halted,
    output mem_rdata, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: 1-cycle-latency instruction fetch feeding a 2-entry {instr, pc} prefetch FIFO
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     resetn,
  fetch_if.master bus
);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc [2];
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        inflight;
  logic        valid;
  logic        pop;
  logic        push;
  logic        issue;
  assign valid = count != 2'd0;
  assign pop = valid && bus.instr_ready;
  assign push = inflight && !bus.redirect;
  // a slot freed by this cycle's pop may be reused at once, giving back-to-back strobes
  assign issue = resetn && !bus.halt && !bus.redirect && (3'(count) + 3'(inflight) - 3'(pop) < 3'd2);
  assign bus.mem_rstrb = issue;
  assign bus.mem_addr = pc;
  assign bus.instr_valid = valid;
  assign bus.instr = valid ? fifo_instr[rd_ptr] : '0;
  assign bus.instr_pc = valid ? fifo_pc[rd_ptr] : '0;
  assign bus.halted = resetn && bus.halt && !inflight;
  // fetch PC, in-flight tracking and FIFO occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc <= START_PC;
      req_pc <= '0;
      inflight <= 1'b0;
      count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (bus.redirect) begin
      pc <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + 32'd4;
        req_pc <= pc;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  // FIFO storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.mem_rdata;
      fifo_pc[wr_ptr] <= req_pc;
    end
  end
endmodule
